display_arbiter: RTL and testbench

- Shares one seven_segment display instance between NUM_CLIENTS requesters, e.g. button counter, debug status, or error code.
- Uses round-robin arbitration with a guaranteed minimum on-screen hold time per grant, so values stay readable.
- Sits between the client logic and seven_segment; drives that block's encoded and digit_point inputs directly.

---
 rtl/display_arb_pkg.sv | 22 ++
 rtl/display_arbiter_rr_arbiter.sv | 28 ++
 rtl/display_arbiter.sv | 124 ++++++++++++
 tb/tb_display_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_arb_pkg.sv
// Shared types and helpers for the display arbiter: FSM states, the hex digit
// type and a one-hot encoder sized for the largest supported client count.
package display_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    typedef logic [3:0] digit_t;

    localparam int MAX_CLIENTS = 8;
    localparam int MAX_IDX_W   = 3;

    function automatic logic [MAX_CLIENTS-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_CLIENTS-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/display_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from the client after `last`,
// wrapping around, so `last` itself is considered only after everyone else.
module rr_arbiter
    import display_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4
) (
    input  logic [NUM_CLIENTS-1:0]         req,
    input  logic [$clog2(NUM_CLIENTS)-1:0] last,
    output logic [$clog2(NUM_CLIENTS)-1:0] winner,
    output logic                           any_req
);

    localparam int IDW = $clog2(NUM_CLIENTS);

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        winner = '0;
        for (int off = NUM_CLIENTS; off >= 1; off--) begin
            winner = req[(int'(last) + off) % NUM_CLIENTS]
                   ? IDW'((int'(last) + off) % NUM_CLIENTS)
                   : winner;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/display_arbiter.sv
// Shares one seven_segment display between several clients using round-robin
// arbitration with a minimum on-screen hold time per grant.
module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int NUM_CLIENTS  = 4,
    parameter int NUM_SEGMENTS = 4,
    parameter int CLK_PER      = 10,
    parameter int HOLD_US      = 500000
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CLIENTS-1:0]                    req,
    input  logic [NUM_CLIENTS-1:0][NUM_SEGMENTS-1:0][3:0] client_encoded,
    input  logic [NUM_CLIENTS-1:0][NUM_SEGMENTS-1:0]  client_dp,
    output logic [NUM_CLIENTS-1:0]                    grant,
    output logic [$clog2(NUM_CLIENTS)-1:0]            active_id,
    output logic [NUM_SEGMENTS-1:0][3:0]              encoded,
    output logic [NUM_SEGMENTS-1:0]                   digit_point
);

    localparam int IDW         = $clog2(NUM_CLIENTS);
    localparam int HOLD_CYCLES = HOLD_US * 1000 / CLK_PER;
    localparam int TW          = $clog2(HOLD_CYCLES);

    state_t                     state_r, state_n;
    logic [TW-1:0]              timer_r, timer_n;
    logic [NUM_CLIENTS-1:0]     grant_r, grant_n;
    logic [IDW-1:0]             active_id_r, active_id_n;
    digit_t [NUM_SEGMENTS-1:0]  encoded_r, encoded_n;
    logic [NUM_SEGMENTS-1:0]    digit_point_r, digit_point_n;

    logic [IDW-1:0]             winner_s;
    logic                       any_req_s;

    // active_id doubles as the round-robin pointer: search starts after it.
    rr_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_rr (
        .req     (req),
        .last    (active_id_r),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            timer_r       <= '0;
            grant_r       <= '0;
            active_id_r   <= '0;
            encoded_r     <= '0;
            digit_point_r <= '1;
        end else begin
            state_r       <= state_n;
            timer_r       <= timer_n;
            grant_r       <= grant_n;
            active_id_r   <= active_id_n;
            encoded_r     <= encoded_n;
            digit_point_r <= digit_point_n;
        end
    end

    // Next-state logic: arbitration, hold timer and display data capture.
    always_comb begin
        state_n       = state_r;
        timer_n       = timer_r;
        grant_n       = grant_r;
        active_id_n   = active_id_r;
        encoded_n     = encoded_r;
        digit_point_n = digit_point_r;

        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    grant_n     = NUM_CLIENTS'(onehot(MAX_IDX_W'(winner_s)));
                    active_id_n = winner_s;
                    timer_n     = TW'(HOLD_CYCLES - 1);
                    state_n     = SHOW;
                end else begin
                    grant_n     = '0;
                end
            end

            SHOW: begin
                // Live update only while the owner asks; otherwise freeze.
                if (req[active_id_r]) begin
                    encoded_n     = client_encoded[active_id_r];
                    digit_point_n = client_dp[active_id_r];
                end else begin
                    encoded_n     = encoded_r;
                    digit_point_n = digit_point_r;
                end

                if (timer_r == '0) begin
                    if (any_req_s) begin
                        // The owner is searched last, so it keeps the
                        // grant only when nobody else is waiting.
                        grant_n     = NUM_CLIENTS'(onehot(MAX_IDX_W'(winner_s)));
                        active_id_n = winner_s;
                        timer_n     = TW'(HOLD_CYCLES - 1);
                    end else begin
                        grant_n     = '0;
                        state_n     = IDLE;
                    end
                end else begin
                    timer_n = timer_r - TW'(1);
                end
            end

            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    assign grant       = grant_r;
    assign active_id   = active_id_r;
    assign encoded     = encoded_r;
    assign digit_point = digit_point_r;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: a cycle model fills a scoreboard
// every clock, plus directed checks of the key arbitration scenarios.
module tb_display_arbiter;

    localparam int NC   = 4;
    localparam int NS   = 4;
    localparam int HOLD = 100;

    logic                    clk;
    logic                    reset;
    logic [NC-1:0]           req;
    logic [NC-1:0][NS-1:0][3:0] client_encoded;
    logic [NC-1:0][NS-1:0]   client_dp;
    logic [NC-1:0]           grant;
    logic [1:0]              active_id;
    logic [NS-1:0][3:0]      encoded;
    logic [NS-1:0]           digit_point;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        show;
        logic [6:0]  timer;
        logic [3:0]  grant;
        logic [1:0]  id;
        logic [15:0] enc;
        logic [3:0]  dp;
    } mstate_t;

    mstate_t m;
    mstate_t sb_q[$];

    display_arbiter #(
        .NUM_CLIENTS  (NC),
        .NUM_SEGMENTS (NS),
        .CLK_PER      (10),
        .HOLD_US      (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .client_encoded (client_encoded),
        .client_dp      (client_dp),
        .grant          (grant),
        .active_id      (active_id),
        .encoded        (encoded),
        .digit_point    (digit_point)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input logic [1:0] last);
        for (int k = 1; k <= NC; k++) begin
            if (r[(int'(last) + k) % NC]) return (int'(last) + k) % NC;
        end
        return 0;
    endfunction

    function automatic mstate_t model_next(input mstate_t cur, input logic rst, input logic [3:0] r,
                                           input logic [3:0][3:0][3:0] ce, input logic [3:0][3:0] cd);
        mstate_t n;
        int w;
        n = cur;
        if (rst) begin
            n = '{show: 1'b0, timer: 7'd0, grant: 4'd0, id: 2'd0, enc: 16'd0, dp: 4'hF};
        end else if (!cur.show) begin
            if (r != 4'd0) begin
                w = rr_pick(r, cur.id);
                n.grant = 4'b0001 << w;
                n.id    = 2'(w);
                n.timer = 7'(HOLD - 1);
                n.show  = 1'b1;
            end else begin
                n.grant = 4'd0;
            end
        end else begin
            if (r[cur.id]) begin
                n.enc = ce[cur.id];
                n.dp  = cd[cur.id];
            end
            if (cur.timer == 7'd0) begin
                if (r != 4'd0) begin
                    w = rr_pick(r, cur.id);
                    n.grant = 4'b0001 << w;
                    n.id    = 2'(w);
                    n.timer = 7'(HOLD - 1);
                end else begin
                    n.grant = 4'd0;
                    n.show  = 1'b0;
                end
            end else begin
                n.timer = cur.timer - 7'd1;
            end
        end
        return n;
    endfunction

    // Model: predict the outputs after each edge and queue them.
    always @(posedge clk) begin
        sb_q.push_back(model_next(m, reset, req, client_encoded, client_dp));
        m <= model_next(m, reset, req, client_encoded, client_dp);
    end

    // Scoreboard: compare DUT outputs just after each edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            check("sb_grant",     grant,       sb_q[0].grant);
            check("sb_active_id", active_id,   sb_q[0].id);
            check("sb_encoded",   encoded,     sb_q[0].enc);
            check("sb_dp",        digit_point, sb_q[0].dp);
            void'(sb_q.pop_front());
        end
    end

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        client_encoded[0] = 16'h0123;
        client_encoded[1] = 16'h4567;
        client_encoded[2] = 16'h2BAD;
        client_encoded[3] = 16'hCDEF;
        client_dp = {4'h7, 4'hB, 4'hD, 4'hE};
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset: display dark, nobody granted.
        repeat (500) @(negedge clk);
        sample();
        check("idle_grant", grant, 32'h0);
        check("idle_enc",   encoded, 32'h0);
        check("idle_dp",    digit_point, 32'hF);

        // Single request: grant after 1 cycle, data one cycle later.
        @(negedge clk); req = 4'b0100;
        sample();
        check("req2_grant", grant, 32'h4);
        check("req2_id",    active_id, 32'h2);
        check("req2_enc_pre", encoded, 32'h0);
        sample();
        check("req2_enc",   encoded, 32'h2BAD);
        check("req2_dp",    digit_point, 32'hB);
        @(negedge clk); client_encoded[2] = 16'h1234;
        sample();
        check("req2_live",  encoded, 32'h1234);
        @(negedge clk); req = 4'b0000;
        repeat (110) @(negedge clk);

        // Wrap from client 2 to client 0.
        req = 4'b0001;
        sample();
        check("wrap_grant", grant, 32'h1);
        @(negedge clk); req = 4'b0000;
        repeat (110) @(negedge clk);

        // All requesting from active_id 0: order 1,2,3,0, 100 cycles each.
        req = 4'b1111;
        for (int k = 0; k < 400; k++) begin
            sample();
            if ((k % HOLD == 0) || (k % HOLD == HOLD - 1))
                check("rr_order", grant, 32'h1 << ((1 + k / HOLD) % NC));
        end
        @(negedge clk); req = 4'b0000;

        // Owner 1 drops early while 3 waits: frozen display, no early release.
        pulse_reset();
        req = 4'b1010;
        client_encoded[1] = 16'h9999;
        for (int k = 0; k <= 100; k++) begin
            sample();
            if (k == 5)  check("drop_live",   encoded, 32'hA004);
            if (k == 50 || k == 99) begin
                check("drop_frozen", encoded, 32'hA009);
                check("drop_hold",   grant, 32'h2);
            end
            if (k == 100) begin
                check("drop_frozen_end", encoded, 32'hA009);
                check("drop_switch",     grant, 32'h8);
            end
            @(negedge clk);
            client_encoded[1] = 16'hA000 + 16'(k);
            req[1] = (k < 10);
        end
        req = 4'b0000;

        // Lone requester keeps the grant across reloads, releases at expiry.
        pulse_reset();
        req = 4'b0001;
        client_encoded[0] = 16'h5678;
        for (int k = 0; k <= 400; k++) begin
            sample();
            if (k == 100 || k == 200 || k == 300 || k == 399)
                check("solo_hold", grant, 32'h1);
            if (k == 400) begin
                check("solo_release", grant, 32'h0);
                check("solo_enc",     encoded, 32'h5678);
            end
            @(negedge clk);
            req[0] = (k < 349);
            if (k >= 349) client_encoded[0] = 16'hFFFF;
        end

        // Reset in the middle of a grant, then re-grant from client 1.
        pulse_reset();
        req = 4'b0100;
        client_encoded[2] = 16'h3C3C;
        for (int k = 0; k <= 50; k++) sample();
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b1110;
        sample();
        check("rst_grant", grant, 32'h0);
        check("rst_enc",   encoded, 32'h0);
        check("rst_dp",    digit_point, 32'hF);
        check("rst_id",    active_id, 32'h0);
        @(negedge clk); reset = 1'b0;
        sample();
        check("rst_regrant", grant, 32'h2);
        check("rst_reid",    active_id, 32'h1);
        @(negedge clk); req = 4'b0000;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
